// File: rtl/panel_loader_if.sv
// Command handshake between the host (UART or bench) and the front-panel loader.
// The host is the master; the loader is the slave.
interface panel_loader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [11:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/panel_loader.sv
// Front-panel sequencer for the q2 CPU: replays host commands as timed switch,
// strobe, reset and start/stop actions, exactly as an operator would by hand.
module panel_loader #(
    parameter int SETTLE_CYCLES = 8,
    parameter int PULSE_CYCLES  = 16,
    parameter int RST_CYCLES    = 32,
    parameter int TW            = 8
) (
    input  logic         clk,
    input  logic         nrst,
    panel_loader_if.slave cmd,
    output logic [11:0]  nsw,
    output logic         ndep_sw,
    output logic         nincp_sw,
    output logic         cpu_nrst,
    output logic         start_pull,
    output logic         stop_pull,
    output logic [11:0]  load_count,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_DEP,
        S_GAP,
        S_INC,
        S_HOLD,
        S_RST,
        S_PULL
    } state_t;

    localparam logic [1:0] OP_DEPOSIT = 2'b00;
    localparam logic [1:0] OP_RESET   = 2'b01;
    localparam logic [1:0] OP_START   = 2'b10;

    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LD  = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] RST_LD    = TW'(RST_CYCLES - 1);

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_op;
    logic [11:0]   r_nsw;
    logic          r_ndep;
    logic          r_nincp;
    logic          r_cpuNrst;
    logic          r_startPull;
    logic          r_stopPull;
    logic [11:0]   r_loadCount;
    logic          r_ready;
    logic          r_busy;

    state_t        w_stateNext;
    logic [TW-1:0] w_timerNext;
    logic [1:0]    w_opNext;
    logic [11:0]   w_nswNext;
    logic [11:0]   w_countNext;
    logic          w_accept;
    logic          w_timerDone;

    assign w_accept    = cmd.cmd_valid & r_ready;
    assign w_timerDone = (r_timer == '0);

    // Each timed state loads N-1 on entry and leaves on the cycle its timer reads zero.
    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        w_opNext    = r_op;
        w_nswNext   = r_nsw;
        w_countNext = r_loadCount;
        if (!w_timerDone) begin
            w_timerNext = r_timer - 1'b1;
        end
        case (r_state)
            S_IDLE: begin
                w_nswNext = '1;
                if (w_accept) begin
                    w_opNext = cmd.cmd_op;
                    case (cmd.cmd_op)
                        OP_DEPOSIT: begin
                            w_stateNext = S_SETUP;
                            w_timerNext = SETTLE_LD;
                            w_nswNext   = ~cmd.cmd_data;
                        end
                        OP_RESET: begin
                            w_stateNext = S_RST;
                            w_timerNext = RST_LD;
                            w_countNext = '0;
                        end
                        default: begin
                            w_stateNext = S_PULL;
                            w_timerNext = PULSE_LD;
                        end
                    endcase
                end
            end
            S_SETUP: if (w_timerDone) begin
                w_stateNext = S_DEP;
                w_timerNext = PULSE_LD;
            end
            S_DEP: if (w_timerDone) begin
                w_stateNext = S_GAP;
                w_timerNext = SETTLE_LD;
            end
            S_GAP: if (w_timerDone) begin
                w_stateNext = S_INC;
                w_timerNext = PULSE_LD;
            end
            S_INC, S_RST, S_PULL: if (w_timerDone) begin
                w_stateNext = S_HOLD;
                w_timerNext = SETTLE_LD;
            end
            S_HOLD: if (w_timerDone) begin
                w_stateNext = S_IDLE;
                w_nswNext   = '1;
                if (r_op == OP_DEPOSIT) begin
                    w_countNext = r_loadCount + 12'd1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_timerNext = '0;
                w_nswNext   = '1;
            end
        endcase
    end

    // Pins are decoded from the next state so every q2-facing output comes straight off a flop.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_op        <= OP_DEPOSIT;
            r_nsw       <= '1;
            r_ndep      <= 1'b1;
            r_nincp     <= 1'b1;
            r_cpuNrst   <= 1'b1;
            r_startPull <= 1'b0;
            r_stopPull  <= 1'b0;
            r_loadCount <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_timer     <= w_timerNext;
            r_op        <= w_opNext;
            r_nsw       <= w_nswNext;
            r_ndep      <= (w_stateNext != S_DEP);
            r_nincp     <= (w_stateNext != S_INC);
            r_cpuNrst   <= (w_stateNext != S_RST);
            r_startPull <= (w_stateNext == S_PULL) && (w_opNext == OP_START);
            r_stopPull  <= (w_stateNext == S_PULL) && (w_opNext != OP_START);
            r_loadCount <= w_countNext;
            r_ready     <= (w_stateNext == S_IDLE);
            r_busy      <= (w_stateNext != S_IDLE);
        end
    end

    assign cmd.cmd_ready = r_ready;
    assign nsw           = r_nsw;
    assign ndep_sw       = r_ndep;
    assign nincp_sw      = r_nincp;
    assign cpu_nrst      = r_cpuNrst;
    assign start_pull    = r_startPull;
    assign stop_pull     = r_stopPull;
    assign load_count    = r_loadCount;
    assign busy          = r_busy;

endmodule
